// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, helpers and state encoding for the streaming 64-point FFT
package fft_pkg;

  localparam int SAMPLE_W = 17;
  localparam int FFT_N    = 64;

  function automatic int f_log2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  localparam int N_STAGES = f_log2(FFT_N);

  // Stage s spans FFT_N >> s points, so its feedback delay is half of that.
  function automatic int f_stage_depth(input int s);
    return FFT_N >> (s + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bf2.sv
// rtl/bf2.sv - radix-2 butterfly: a+b and a-b, keeping the sign bit and dropping bit WIDTH-1 of the WIDTH+1 result
module bf2 #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] i_a_re,
  input  logic [WIDTH-1:0] i_a_im,
  input  logic [WIDTH-1:0] i_b_re,
  input  logic [WIDTH-1:0] i_b_im,
  output logic [WIDTH-1:0] o_sum_re,
  output logic [WIDTH-1:0] o_sum_im,
  output logic [WIDTH-1:0] o_diff_re,
  output logic [WIDTH-1:0] o_diff_im
);

  // Low bits are added directly; the top result bit is rebuilt from the carry
  // out of the sign position, so the discarded bit is never formed.
  function automatic logic [WIDTH-1:0] f_addsub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] lo;
    logic             c;
    logic             co;
    bb = sub ? ~b : b;
    lo = {1'b0, a[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + WIDTH'(sub);
    c  = lo[WIDTH-1];
    co = (a[WIDTH-1] & bb[WIDTH-1]) | (c & (a[WIDTH-1] ^ bb[WIDTH-1]));
    return {co ^ a[WIDTH-1] ^ bb[WIDTH-1], lo[WIDTH-2:0]};
  endfunction

  assign o_sum_re  = f_addsub(i_a_re, i_b_re, 1'b0);
  assign o_sum_im  = f_addsub(i_a_im, i_b_im, 1'b0);
  assign o_diff_re = f_addsub(i_a_re, i_b_re, 1'b1);
  assign o_diff_im = f_addsub(i_a_im, i_b_im, 1'b1);

endmodule

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - enable-gated shift register; head is the word written DEPTH enables ago
module sdf_delay_line #(
  parameter int W     = 34,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_sr[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_head = r_sr[DEPTH-1];

endmodule

// File: rtl/bf2_sdf_stage.sv
// rtl/bf2_sdf_stage.sv - radix-2 single-path delay-feedback stage with self-draining final frame
module bf2_sdf_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = f_stage_depth(0),
  parameter int IDXW  = f_log2(FFT_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDXW-1:0] L_D     = IDXW'(DEPTH);
  localparam logic [IDXW-1:0] L_DLAST = IDXW'(DEPTH - 1);
  localparam logic [IDXW-1:0] L_WRAP  = IDXW'(2 * DEPTH - 1);

  state_e            r_state;
  state_e            w_next;
  logic [IDXW-1:0]   r_cnt;
  logic              r_primed;
  logic              w_accept;
  logic              w_phase_a;
  logic              w_wrap;
  logic              w_drain;
  logic              w_drain_end;
  logic [WIDTH-1:0]  w_head_re;
  logic [WIDTH-1:0]  w_head_im;
  logic [WIDTH-1:0]  w_sum_re;
  logic [WIDTH-1:0]  w_sum_im;
  logic [WIDTH-1:0]  w_diff_re;
  logic [WIDTH-1:0]  w_diff_im;
  logic [2*WIDTH-1:0] w_dl_in;

  assign w_accept    = in_valid & in_ready;
  assign w_phase_a   = r_cnt < L_D;
  assign w_wrap      = r_cnt == L_WRAP;
  assign w_drain     = r_state == ST_DRAIN;
  assign w_drain_end = w_drain && (r_cnt == L_DLAST);

  bf2 #(.WIDTH(WIDTH)) u_bf2 (
    .i_a_re    (w_head_re),
    .i_a_im    (w_head_im),
    .i_b_re    (in_re),
    .i_b_im    (in_im),
    .o_sum_re  (w_sum_re),
    .o_sum_im  (w_sum_im),
    .o_diff_re (w_diff_re),
    .o_diff_im (w_diff_im)
  );

  // Phase A stores raw input; phase B stores the difference. Drain only shifts.
  assign w_dl_in = w_phase_a ? {in_re, in_im} : {w_diff_re, w_diff_im};

  sdf_delay_line #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_dl (
    .clk    (clk),
    .i_en   (w_accept | w_drain),
    .i_data (w_dl_in),
    .o_head ({w_head_re, w_head_im})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_RUN;
      ST_RUN:   if (w_accept && in_last && w_wrap) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    if (r_state == ST_DRAIN) in_ready = 1'b0;
    if (r_state != ST_IDLE || r_primed) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
    end else if (w_accept) begin
      out_last <= 1'b0;
      r_cnt    <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_phase_a) begin
        out_valid <= r_primed;
        out_re    <= w_head_re;
        out_im    <= w_head_im;
        out_idx   <= r_cnt + L_D;
      end else begin
        out_valid <= 1'b1;
        out_re    <= w_sum_re;
        out_im    <= w_sum_im;
        out_idx   <= r_cnt - L_D;
        if (w_wrap) r_primed <= 1'b1;
      end
    end else if (w_drain) begin
      out_valid <= 1'b1;
      out_re    <= w_head_re;
      out_im    <= w_head_im;
      out_idx   <= r_cnt + L_D;
      out_last  <= w_drain_end;
      r_cnt     <= w_drain_end ? '0 : r_cnt + 1'b1;
      if (w_drain_end) r_primed <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// tb/tb_bf2_sdf_stage.sv - scoreboard bench for bf2_sdf_stage at DEPTH=4 and DEPTH=1
module tb_bf2_sdf_stage;

  typedef struct {
    logic [16:0] re;
    logic [16:0] im;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    logic [16:0] re;
    logic [16:0] im;
  } cplx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        i4_valid = 1'b0, i4_last = 1'b0;
  logic [16:0] i4_re = '0, i4_im = '0;
  logic        o4_ready, o4_valid, o4_last, o4_busy;
  logic [16:0] o4_re, o4_im;
  logic [5:0]  o4_idx;

  logic        i1_valid = 1'b0, i1_last = 1'b0;
  logic [16:0] i1_re = '0, i1_im = '0;
  logic        o1_ready, o1_valid, o1_last, o1_busy;
  logic [16:0] o1_re, o1_im;
  logic [5:0]  o1_idx;

  int n_checks = 0;
  int n_errors = 0;

  exp_t  exp4[$];
  exp_t  exp1[$];
  exp_t  e4, e1;
  cplx_t m_dl[$];
  int    m_cnt = 0;
  int    m_d = 4;
  bit    m_primed = 0;

  always #5 clk = ~clk;

  bf2_sdf_stage #(.WIDTH(17), .DEPTH(4), .IDXW(6)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(o4_ready), .in_last(i4_last),
    .in_re(i4_re), .in_im(i4_im), .out_valid(o4_valid), .out_re(o4_re), .out_im(o4_im),
    .out_idx(o4_idx), .out_last(o4_last), .busy(o4_busy)
  );

  bf2_sdf_stage #(.WIDTH(17), .DEPTH(1), .IDXW(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(o1_ready), .in_last(i1_last),
    .in_re(i1_re), .in_im(i1_im), .out_valid(o1_valid), .out_re(o1_re), .out_im(o1_im),
    .out_idx(o1_idx), .out_last(o1_last), .busy(o1_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] bf(input logic [16:0] a, input logic [16:0] b, input bit sub);
    logic [17:0] ea, eb, s;
    ea = {a[16], a};
    eb = {b[16], b};
    s  = sub ? ea - eb : ea + eb;
    return {s[17], s[15:0]};
  endfunction

  task automatic push_exp(input int sel, input logic [16:0] re, input logic [16:0] im,
                          input int idx, input bit last);
    exp_t e;
    e.re = re; e.im = im; e.idx = 6'(idx); e.last = last;
    if (sel == 1) exp1.push_back(e);
    else          exp4.push_back(e);
  endtask

  task automatic model_reset(input int d);
    m_d = d; m_cnt = 0; m_primed = 0;
    m_dl.delete();
  endtask

  task automatic model_accept(input int sel, input logic [16:0] re, input logic [16:0] im, input bit last);
    cplx_t a, n;
    n.re = re; n.im = im;
    if (m_cnt < m_d) begin
      if (m_primed) begin
        a = m_dl.pop_front();
        push_exp(sel, a.re, a.im, m_cnt + m_d, 0);
      end
      m_dl.push_back(n);
    end else begin
      a = m_dl.pop_front();
      push_exp(sel, bf(a.re, re, 0), bf(a.im, im, 0), m_cnt - m_d, 0);
      n.re = bf(a.re, re, 1); n.im = bf(a.im, im, 1);
      m_dl.push_back(n);
      if (m_cnt == 2 * m_d - 1) m_primed = 1;
    end
    if (last && m_cnt == 2 * m_d - 1) begin
      for (int i = 0; i < m_d; i++) begin
        a = m_dl.pop_front();
        push_exp(sel, a.re, a.im, m_d + i, i == m_d - 1);
      end
      m_primed = 0;
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1) % (2 * m_d);
    end
  endtask

  task automatic drive(input int sel, input bit v, input bit last, input int re, input int im);
    if (sel == 1) begin i1_valid = v; i1_last = last; i1_re = 17'(re); i1_im = 17'(im); end
    else          begin i4_valid = v; i4_last = last; i4_re = 17'(re); i4_im = 17'(im); end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? o1_ready : o4_ready;
  endfunction

  task automatic send(input int sel, input int re, input int im, input bit last);
    int t = 0;
    @(negedge clk);
    drive(sel, 1, last, re, im);
    while (!rdy(sel) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("send_ready_timeout", rdy(sel), 1);
    else         model_accept(sel, 17'(re), 17'(im), last);
  endtask

  task automatic idle(input int sel);
    @(negedge clk);
    drive(sel, 0, 0, 0, 0);
  endtask

  task automatic count_drain(input int sel, input bit hold, input int d);
    int n = 0;
    @(negedge clk);
    if (!hold) drive(sel, 0, 0, 0, 0);
    while (!rdy(sel) && n < 40) begin n++; @(negedge clk); end
    drive(sel, 0, 0, 0, 0);
    check("drain_ready_low_cycles", n, d);
    check("idle_after_drain_busy", (sel == 1) ? o1_busy : o4_busy, 0);
  endtask

  task automatic wait_empty(input int sel);
    int t = 0;
    while (((sel == 1) ? exp1.size() : exp4.size()) > 0 && t < 40) begin @(negedge clk); t++; end
    check("scoreboard_drained", (sel == 1) ? exp1.size() : exp4.size(), 0);
  endtask

  task automatic frame(input int base, input int im_mul, input bit last, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send(0, base + i, im_mul * (base + i), last && i == 7);
      if (gaps && i != 7) idle(0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o4_valid) begin
      if (exp4.size() == 0) check("d4_spurious_valid", o4_valid, 0);
      else begin
        e4 = exp4.pop_front();
        check("d4_out{re,im,idx,last}", {o4_re, o4_im, o4_idx, o4_last}, {e4.re, e4.im, e4.idx, e4.last});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && o1_valid) begin
      if (exp1.size() == 0) check("d1_spurious_valid", o1_valid, 0);
      else begin
        e1 = exp1.pop_front();
        check("d1_out{re,im,idx,last}", {o1_re, o1_im, o1_idx, o1_last}, {e1.re, e1.im, e1.idx, e1.last});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", o4_valid, 0);
    check("rst_in_ready", o4_ready, 1);
    check("rst_busy", o4_busy, 0);
    check("rst_out_idx", o4_idx, 0);
    check("rst_out_last", o4_last, 0);
    check("rst_d1_in_ready", o1_ready, 1);
    rst_n = 1'b1;

    // Single frame 1..8: sums 6,8,10,12 then -4 x4
    model_reset(4);
    frame(1, 0, 1, 0);
    count_drain(0, 0, 4);
    wait_empty(0);

    // Back-to-back frames, second with last
    model_reset(4);
    frame(1, 2, 0, 0);
    frame(11, 2, 1, 0);
    count_drain(0, 0, 4);
    wait_empty(0);

    // Gapped input stream
    model_reset(4);
    frame(1, -1, 1, 1);
    count_drain(0, 0, 4);
    wait_empty(0);

    // Early in_last ignored; in_valid held through drain
    model_reset(4);
    for (int i = 1; i <= 4; i++) send(0, i, 3, i == 4);
    idle(0);
    check("early_last_ready", o4_ready, 1);
    check("early_last_busy", o4_busy, 1);
    for (int i = 5; i <= 8; i++) send(0, i, 3, i == 8);
    count_drain(0, 1, 4);
    wait_empty(0);
    frame(1, 0, 1, 0);
    count_drain(0, 0, 4);
    wait_empty(0);

    // Asynchronous reset after five accepts, then a clean frame
    model_reset(4);
    for (int i = 1; i <= 5; i++) send(0, i, 0, 0);
    idle(0);
    check("pre_reset_busy", o4_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", o4_valid, 0);
    check("async_rst_busy", o4_busy, 0);
    check("async_rst_in_ready", o4_ready, 1);
    check("async_rst_out_idx", o4_idx, 0);
    exp4.delete();
    model_reset(4);
    @(negedge clk);
    rst_n = 1'b1;
    frame(21, 0, 1, 0);
    count_drain(0, 0, 4);
    wait_empty(0);

    // DEPTH=1 wrap: 65535+1 -> 0, 65535-1 -> 65534
    model_reset(1);
    send(1, 65535, 0, 0);
    send(1, 1, 0, 1);
    count_drain(1, 0, 1);
    wait_empty(1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
